imem_fetch_responder: RTL and testbench



---
 rtl/imem_pkg.sv | 16 +
 rtl/imem_fetch_responder_resp_fifo.sv | 44 ++++
 rtl/imem_fetch_responder.sv | 130 +++++++++++++
 tb/tb_imem_fetch_responder.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared widths, the NOP encoding and the response record used by the
// instruction-fetch responder pipeline and its response buffer.
package imem_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 64;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [INSTR_W-1:0] instr;
        logic               err;
    } resp_t;

endpackage

// File: rtl/imem_fetch_responder_resp_fifo.sv
// In-order response buffer with extra-MSB pointers, so full and empty can be
// told apart without a separate flag register.
module resp_fifo #(
    parameter type T          = logic,
    parameter int  FIFO_DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          push_i,
    input  T                              push_data_i,
    input  logic                          pop_i,
    output T                              head_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o,
    output logic                          full_o,
    output logic                          empty_o
);

    localparam int PW = $clog2(FIFO_DEPTH);

    T           mem_q [FIFO_DEPTH];
    logic [PW:0] wr_ptr_q;
    logic [PW:0] rd_ptr_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push_i) mem_q[wr_ptr_q[PW-1:0]] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q[PW-1:0]];
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction-fetch responder: ROM read, fixed-latency delay chain and an
// in-order response FIFO, with slot reservation so the FIFO never overflows.
module imem_fetch_responder
    import imem_pkg::*;
#(
    parameter int    DEPTH      = 256,
    parameter int    LATENCY    = 2,
    parameter int    FIFO_DEPTH = 4,
    parameter string INIT_FILE  = ""
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [ADDR_W-1:0]  req_addr,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [INSTR_W-1:0] resp_instr,
    output logic [ADDR_W-1:0]  resp_addr,
    output logic               resp_err,
    output logic               busy
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [INSTR_W-1:0] rom [DEPTH];

    initial begin
        for (int i = 0; i < DEPTH; i++) rom[i] = '0;
    end

    logic             accept;
    logic             pop;
    logic             bad_addr;
    logic [CNT_W-1:0] occ_q;
    logic [CNT_W-1:0] occ_d;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    resp_t            fifo_head;

    assign accept   = req_valid && req_ready;
    assign bad_addr = (req_addr[1:0] != 2'b00) ||
                      (req_addr[ADDR_W-1:2] >= (ADDR_W-2)'(DEPTH));

    // Stage 1: registered ROM read plus the request's address and error flag.
    logic               s1_valid_q;
    logic [ADDR_W-1:0]  s1_addr_q;
    logic               s1_err_q;
    logic [INSTR_W-1:0] s1_rom_q;

    always_ff @(posedge clock) begin
        if (reset) s1_valid_q <= 1'b0;
        else       s1_valid_q <= accept;
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            s1_addr_q <= req_addr;
            s1_err_q  <= bad_addr;
            s1_rom_q  <= rom[req_addr[IDX_W+1:2]];
        end
    end

    resp_t [LATENCY-1:0] stage_e;
    logic  [LATENCY-1:0] stage_v;

    assign stage_v[0]       = s1_valid_q;
    assign stage_e[0].addr  = s1_addr_q;
    assign stage_e[0].instr = s1_err_q ? NOP_INSTR : s1_rom_q;
    assign stage_e[0].err   = s1_err_q;

    for (genvar k = 1; k < LATENCY; k++) begin : g_dly
        resp_t e_q;
        logic  v_q;

        always_ff @(posedge clock) begin
            if (reset) v_q <= 1'b0;
            else       v_q <= stage_v[k-1];
        end

        always_ff @(posedge clock) begin
            e_q <= stage_e[k-1];
        end

        assign stage_v[k] = v_q;
        assign stage_e[k] = e_q;
    end

    resp_fifo #(
        .T          (resp_t),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_resp_fifo (
        .clock       (clock),
        .reset       (reset),
        .push_i      (stage_v[LATENCY-1]),
        .push_data_i (stage_e[LATENCY-1]),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Occupancy covers in-flight and buffered entries, reserving a FIFO slot
    // at acceptance time.
    always_comb begin
        occ_d = occ_q;
        case ({accept, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) occ_q <= '0;
        else       occ_q <= occ_d;
    end

    assign req_ready  = (occ_q < CNT_W'(FIFO_DEPTH)) && !fifo_full;
    assign busy       = (occ_q != '0) || (fifo_count != '0);
    assign resp_valid = !fifo_empty;
    assign pop        = resp_valid && resp_ready;
    assign resp_instr = resp_valid ? fifo_head.instr : '0;
    assign resp_addr  = resp_valid ? fifo_head.addr  : '0;
    assign resp_err   = resp_valid ? fifo_head.err   : 1'b0;

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Directed and randomized checks of the fetch responder against a
// transaction-level model: an ordered list of accepted fetches with due times.
module tb_imem_fetch_responder;

    localparam int DEPTH = 256;
    localparam int LAT   = 2;
    localparam int FD    = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_instr;
    logic [63:0] resp_addr;
    logic        resp_err;
    logic        busy;

    imem_fetch_responder #(
        .DEPTH      (DEPTH),
        .LATENCY    (LAT),
        .FIFO_DEPTH (FD),
        .INIT_FILE  ("")
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_instr (resp_instr),
        .resp_addr  (resp_addr),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] instr;
        logic        err;
        int          due;
    } exp_t;

    exp_t        q[$];
    logic [31:0] rom_m [DEPTH];
    int          edge_n = 0;
    int          errors = 0;
    int          checks = 0;

    function automatic exp_t expect_for(input logic [63:0] a, input int due);
        exp_t e;
        e.addr  = a;
        e.err   = (a % 4 != 0) || ((a / 4) >= 64'(DEPTH));
        e.instr = e.err ? 32'h00000013 : rom_m[int'(a / 4)];
        e.due   = due;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    function automatic logic model_valid();
        return (q.size() > 0) && (q[0].due <= edge_n);
    endfunction

    task automatic check_outputs();
        logic mv;
        mv = model_valid();
        chk("req_ready", 64'(req_ready), 64'(q.size() < FD));
        chk("busy", 64'(busy), 64'(q.size() > 0));
        chk("resp_valid", 64'(resp_valid), 64'(mv));
        if (mv) begin
            chk("resp_instr", 64'(resp_instr), 64'(q[0].instr));
            chk("resp_addr", resp_addr, q[0].addr);
            chk("resp_err", 64'(resp_err), 64'(q[0].err));
        end
    endtask

    // One cycle: drive inputs just after the falling edge, check, clock, update the model.
    task automatic step(input logic rv, input logic [63:0] a, input logic rr);
        logic acc;
        logic pp;
        req_valid  = rv;
        req_addr   = a;
        resp_ready = rr;
        #1;
        check_outputs();
        acc = rv && (q.size() < FD);
        pp  = model_valid() && rr;
        @(posedge clock);
        edge_n++;
        if (pp)  void'(q.pop_front());
        if (acc) q.push_back(expect_for(a, edge_n + LAT));
        @(negedge clock);
    endtask

    task automatic do_reset();
        req_valid  = 1'b0;
        req_addr   = '0;
        resp_ready = 1'b0;
        reset      = 1'b1;
        @(posedge clock);
        edge_n++;
        q.delete();
        @(negedge clock);
        #1;
        chk("rst_resp_valid", 64'(resp_valid), 64'(0));
        chk("rst_resp_instr", 64'(resp_instr), 64'(0));
        chk("rst_resp_addr", resp_addr, 64'(0));
        chk("rst_resp_err", 64'(resp_err), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_req_ready", 64'(req_ready), 64'(1));
        reset = 1'b0;
    endtask

    task automatic idle(input int n, input logic rr);
        for (int i = 0; i < n; i++) step(1'b0, 64'(0), rr);
    endtask

    initial begin
        logic [63:0] a;
        int          sel;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_addr   = '0;
        resp_ready = 1'b0;
        #1;
        for (int i = 0; i < DEPTH; i++) begin
            rom_m[i]   = $urandom;
            rom_m[0]   = 32'hDEADBEEF;
            dut.rom[i] = rom_m[i];
        end
        @(negedge clock);
        do_reset();

        // Single fetch of ROM[0].
        step(1'b1, 64'(0), 1'b1);
        idle(4, 1'b1);

        // Streaming with the consumer always ready.
        for (int i = 0; i < 4; i++) step(1'b1, 64'(4 * i), 1'b1);
        idle(5, 1'b1);

        // Backpressure: only FD requests get in, then drain in order.
        for (int i = 0; i < 6; i++) step(1'b1, 64'(16 + 4 * i), 1'b0);
        idle(3, 1'b0);
        idle(6, 1'b1);

        // Misaligned and out-of-range fetches, then a legal one.
        step(1'b1, 64'h2, 1'b1);
        step(1'b1, 64'(4 * DEPTH), 1'b1);
        step(1'b1, 64'h8000_0000_0000_0000, 1'b1);
        step(1'b1, 64'h8, 1'b1);
        step(1'b1, 64'(4 * DEPTH - 4), 1'b1);
        idle(6, 1'b1);

        // Fill up, then release the consumer while entries are still landing.
        for (int i = 0; i < 4; i++) step(1'b1, 64'(40 + 4 * i), 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 64'(80 + 4 * i), 1'b1);
        idle(6, 1'b1);

        // Reset with entries both buffered and in flight; nothing stale may follow.
        for (int i = 0; i < 4; i++) step(1'b1, 64'(100 + 4 * i), 1'b0);
        do_reset();
        idle(6, 1'b1);

        // Randomized traffic.
        for (int n = 0; n < 500; n++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 7)      a = 64'(4 * $urandom_range(0, DEPTH - 1));
            else if (sel < 8) a = 64'($urandom_range(0, 4 * DEPTH - 1)) | 64'h1;
            else              a = {$urandom, $urandom} | 64'h0000_0400_0000_0000;
            step(($urandom % 4) != 0, a, ($urandom % 3) != 0);
        end
        idle(8, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
